// File: rtl/vpattern_gen.sv
// vpattern_gen: synthesizable video stimulus source producing do/de/hs/vs
// with runtime geometry, blanking, pixel sparsity, pattern and channel count.
module vpattern_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CH_COUNT    = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [CNT_WIDTH-1:0]            reg_width,
  input  logic [CNT_WIDTH-1:0]            reg_height,
  input  logic [CNT_WIDTH-1:0]            reg_hblank,
  input  logic [CNT_WIDTH-1:0]            reg_vblank,
  input  logic [3:0]                      reg_de_period,
  input  logic [1:0]                      reg_pattern,
  input  logic [PIXEL_WIDTH-1:0]          reg_const,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic [CNT_WIDTH-1:0]            frame_cnt_o,
  output logic                            busy_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  localparam int DW = CH_COUNT * PIXEL_WIDTH;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   x_q, x_d, y_q, y_d, blank_q, blank_d;
  logic [3:0]             slot_q, slot_d;

  logic [CNT_WIDTH-1:0]   width_q, width_d, height_q, height_d;
  logic [CNT_WIDTH-1:0]   hblank_q, hblank_d, vblank_q, vblank_d;
  logic [3:0]             period_q, period_d;
  logic [1:0]             pattern_q, pattern_d;
  logic [PIXEL_WIDTH-1:0] const_q, const_d;

  logic [DW-1:0]          do_q, do_d;
  logic                   de_q, de_d, hs_q, hs_d, vs_q, vs_d, busy_q, busy_d;
  logic [CNT_WIDTH-1:0]   frame_q, frame_d;

  logic                   loadCfg, startOk;
  logic [3:0]             pLast;
  logic [CNT_WIDTH-1:0]   hbLast, vbLast;

  // Pixel value for every channel: channel c carries base + c, wrapping per channel.
  function automatic logic [DW-1:0] pixelOf(input logic [CNT_WIDTH-1:0] xv,
                                            input logic [CNT_WIDTH-1:0] yv,
                                            input logic [1:0] pat,
                                            input logic [PIXEL_WIDTH-1:0] cv);
    logic [PIXEL_WIDTH-1:0] base;
    logic [PIXEL_WIDTH-1:0] xt;
    logic [PIXEL_WIDTH-1:0] yt;
    logic [DW-1:0]          result;
    xt = PIXEL_WIDTH'(xv);
    yt = PIXEL_WIDTH'(yv);
    case (pat)
      2'd0:    base = xt;
      2'd1:    base = yt;
      2'd2:    base = xt + yt;
      default: base = cv;
    endcase
    result = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      result[c*PIXEL_WIDTH +: PIXEL_WIDTH] = base + PIXEL_WIDTH'(c);
    end
    return result;
  endfunction

  // Next state, counters, shadow config and next-cycle outputs; the shadow
  // registers pass the live reg_* values through whenever they are being loaded
  // so the first cycle of a frame already uses the new configuration.
  always_comb begin
    vbLast  = (vblank_q <= CNT_WIDTH'(1)) ? '0 : vblank_q - CNT_WIDTH'(1);
    loadCfg = (state_q == IDLE) || ((state_q == VBLANK) && (blank_q == vbLast));

    width_d   = loadCfg ? reg_width     : width_q;
    height_d  = loadCfg ? reg_height    : height_q;
    hblank_d  = loadCfg ? reg_hblank    : hblank_q;
    vblank_d  = loadCfg ? reg_vblank    : vblank_q;
    period_d  = loadCfg ? reg_de_period : period_q;
    pattern_d = loadCfg ? reg_pattern   : pattern_q;
    const_d   = loadCfg ? reg_const     : const_q;

    pLast   = (period_d <= 4'd1) ? 4'd0 : period_d - 4'd1;
    hbLast  = (hblank_d <= CNT_WIDTH'(1)) ? '0 : hblank_d - CNT_WIDTH'(1);
    startOk = en_i && (width_d != '0) && (height_d != '0);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    slot_d  = slot_q;
    blank_d = blank_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          slot_d  = '0;
        end
      end
      ACTIVE: begin
        if (slot_q == pLast) begin
          if (x_q == width_d - CNT_WIDTH'(1)) begin
            blank_d = '0;
            if (y_q == height_d - CNT_WIDTH'(1)) begin
              state_d = VBLANK;
              frame_d = frame_q + CNT_WIDTH'(1);
            end else begin
              state_d = HBLANK;
            end
          end else begin
            x_d    = x_q + CNT_WIDTH'(1);
            slot_d = '0;
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      HBLANK: begin
        if (blank_q == hbLast) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = y_q + CNT_WIDTH'(1);
          slot_d  = '0;
        end else begin
          blank_d = blank_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        if (blank_q == vbLast) begin
          if (startOk) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            slot_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_d = blank_q + CNT_WIDTH'(1);
        end
      end
    endcase

    de_d   = (state_d == ACTIVE) && (slot_d == pLast);
    hs_d   = (state_d != ACTIVE);
    vs_d   = (state_d == ACTIVE) || (state_d == HBLANK);
    busy_d = (state_d != IDLE);
    do_d   = de_d ? pixelOf(x_d, y_d, pattern_d, const_d) : do_q;
  end

  // State, counters, shadow config and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      slot_q    <= '0;
      blank_q   <= '0;
      width_q   <= '0;
      height_q  <= '0;
      hblank_q  <= '0;
      vblank_q  <= '0;
      period_q  <= '0;
      pattern_q <= '0;
      const_q   <= '0;
      do_q      <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      slot_q    <= slot_d;
      blank_q   <= blank_d;
      width_q   <= width_d;
      height_q  <= height_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      const_q   <= const_d;
      do_q      <= do_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
    end
  end

  assign do_o        = do_q;
  assign de_o        = de_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_vpattern_gen.sv
// tb_vpattern_gen: directed, table-driven bench for vpattern_gen with three channels.
module tb_vpattern_gen;

  localparam int PW = 8;
  localparam int CH = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic [CW-1:0] reg_width, reg_height, reg_hblank, reg_vblank;
  logic [3:0]    reg_de_period;
  logic [1:0]    reg_pattern;
  logic [PW-1:0] reg_const;
  logic [CH*PW-1:0] do_o;
  logic          de_o, hs_o, vs_o, busy_o;
  logic [CW-1:0] frame_cnt_o;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic        en;
    logic        de;
    logic        hs;
    logic        vs;
    logic        busy;
    logic [23:0] dout;
    logic [15:0] fc;
  } vec_t;

  vec_t denseVec[17];

  vpattern_gen #(.PIXEL_WIDTH(PW), .CH_COUNT(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .reg_width(reg_width), .reg_height(reg_height),
    .reg_hblank(reg_hblank), .reg_vblank(reg_vblank),
    .reg_de_period(reg_de_period), .reg_pattern(reg_pattern), .reg_const(reg_const),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setConfig(input int w, input int h, input int hb, input int vb,
                           input int p, input int pat, input int cv);
    reg_width     = CW'(w);
    reg_height    = CW'(h);
    reg_hblank    = CW'(hb);
    reg_vblank    = CW'(vb);
    reg_de_period = 4'(p);
    reg_pattern   = 2'(pat);
    reg_const     = PW'(cv);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    en_i = 1'b0;
    stepCycles(2);
    rst  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    en_i = v.en;
    stepCycles(1);
    checkOutput($sformatf("dense[%0d].de", idx),   32'(de_o),        32'(v.de));
    checkOutput($sformatf("dense[%0d].hs", idx),   32'(hs_o),        32'(v.hs));
    checkOutput($sformatf("dense[%0d].vs", idx),   32'(vs_o),        32'(v.vs));
    checkOutput($sformatf("dense[%0d].busy", idx), 32'(busy_o),      32'(v.busy));
    checkOutput($sformatf("dense[%0d].do", idx),   32'(do_o),        32'(v.dout));
    checkOutput($sformatf("dense[%0d].fc", idx),   32'(frame_cnt_o), 32'(v.fc));
  endtask

  // Directed test sequence.
  initial begin
    logic [7:0] bx;
    logic       expDe;

    // W=4 H=2 hblank=3 vblank=5 P=1 diagonal, three channels {b+2,b+1,b}
    denseVec[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h020100, 16'd0};
    denseVec[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h030201, 16'd0};
    denseVec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h040302, 16'd0};
    denseVec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h050403, 16'd0};
    denseVec[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h050403, 16'd0};
    denseVec[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h050403, 16'd0};
    denseVec[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h050403, 16'd0};
    denseVec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h030201, 16'd0};
    denseVec[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h040302, 16'd0};
    denseVec[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h050403, 16'd0};
    denseVec[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h060504, 16'd0};
    denseVec[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h060504, 16'd1};
    denseVec[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h060504, 16'd1};
    denseVec[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h060504, 16'd1};
    denseVec[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h060504, 16'd1};
    denseVec[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h060504, 16'd1};
    denseVec[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h020100, 16'd1};

    setConfig(4, 2, 3, 5, 1, 2, 0);
    rst  = 1'b1;
    en_i = 1'b1;
    stepCycles(2);
    checkOutput("reset.do",   32'(do_o),        32'h0);
    checkOutput("reset.de",   32'(de_o),        32'h0);
    checkOutput("reset.hs",   32'(hs_o),        32'h1);
    checkOutput("reset.vs",   32'(vs_o),        32'h0);
    checkOutput("reset.fc",   32'(frame_cnt_o), 32'h0);
    checkOutput("reset.busy", 32'(busy_o),      32'h0);
    rst = 1'b0;

    // Dense diagonal, two frames; width change during frame 1 must be ignored
    for (int i = 0; i < 17; i++) applyStimulus(denseVec[i], i);
    reg_width = CW'(2);
    stepCycles(10);
    checkOutput("dense.f1end.vs", 32'(vs_o), 32'h1);
    stepCycles(1);
    checkOutput("dense.f1vb.vs", 32'(vs_o),        32'h0);
    checkOutput("dense.f1vb.fc", 32'(frame_cnt_o), 32'h2);

    // Sparse P=2, pattern x
    doReset();
    setConfig(4, 2, 3, 5, 2, 0, 0);
    en_i = 1'b1;
    for (int line = 0; line < 2; line++) begin
      for (int i = 0; i < 8; i++) begin
        stepCycles(1);
        expDe = (i % 2 == 1);
        checkOutput($sformatf("sparse.l%0d.c%0d.de", line, i), 32'(de_o), 32'(expDe));
        checkOutput($sformatf("sparse.l%0d.c%0d.hs", line, i), 32'(hs_o), 32'h0);
        if (expDe) begin
          bx = 8'(i / 2);
          checkOutput($sformatf("sparse.l%0d.c%0d.do", line, i), 32'(do_o),
                      32'({bx + 8'd2, bx + 8'd1, bx}));
        end
      end
      for (int i = 0; i < ((line == 0) ? 3 : 5); i++) begin
        stepCycles(1);
        checkOutput($sformatf("sparse.l%0d.b%0d.hs", line, i), 32'(hs_o), 32'h1);
        checkOutput($sformatf("sparse.l%0d.b%0d.vs", line, i), 32'(vs_o), (line == 0) ? 32'h1 : 32'h0);
        checkOutput($sformatf("sparse.l%0d.b%0d.de", line, i), 32'(de_o), 32'h0);
      end
    end
    stepCycles(1);
    checkOutput("sparse.next.vs", 32'(vs_o), 32'h1);
    checkOutput("sparse.next.hs", 32'(hs_o), 32'h0);
    checkOutput("sparse.next.de", 32'(de_o), 32'h0);

    // Multichannel constant with wrap on channel 2
    doReset();
    setConfig(4, 2, 3, 5, 1, 3, 8'hFE);
    en_i = 1'b1;
    stepCycles(1);
    checkOutput("mc.do0", 32'(do_o), 32'h00FFFE);
    checkOutput("mc.de0", 32'(de_o), 32'h1);
    stepCycles(1);
    checkOutput("mc.do1", 32'(do_o), 32'h00FFFE);

    // Graceful stop: en dropped during line 0
    doReset();
    setConfig(4, 2, 3, 5, 1, 0, 0);
    en_i = 1'b1;
    stepCycles(1);
    en_i = 1'b0;
    stepCycles(10);
    checkOutput("stop.c11.vs", 32'(vs_o), 32'h1);
    stepCycles(1);
    checkOutput("stop.c12.vs", 32'(vs_o),        32'h0);
    checkOutput("stop.c12.hs", 32'(hs_o),        32'h1);
    checkOutput("stop.c12.fc", 32'(frame_cnt_o), 32'h1);
    stepCycles(4);
    checkOutput("stop.c16.busy", 32'(busy_o), 32'h1);
    stepCycles(1);
    checkOutput("stop.idle.busy", 32'(busy_o),      32'h0);
    checkOutput("stop.idle.hs",   32'(hs_o),        32'h1);
    checkOutput("stop.idle.vs",   32'(vs_o),        32'h0);
    checkOutput("stop.idle.fc",   32'(frame_cnt_o), 32'h1);
    stepCycles(3);
    checkOutput("stop.stay.busy", 32'(busy_o), 32'h0);
    checkOutput("stop.stay.de",   32'(de_o),   32'h0);

    // Reset on the third active pixel
    doReset();
    setConfig(4, 2, 3, 5, 1, 0, 0);
    en_i = 1'b1;
    stepCycles(3);
    checkOutput("rstmid.px2.do", 32'(do_o), 32'h040302);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("rstmid.do",   32'(do_o),   32'h0);
    checkOutput("rstmid.de",   32'(de_o),   32'h0);
    checkOutput("rstmid.hs",   32'(hs_o),   32'h1);
    checkOutput("rstmid.vs",   32'(vs_o),   32'h0);
    checkOutput("rstmid.busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    stepCycles(1);
    checkOutput("rstmid.restart.de", 32'(de_o), 32'h1);
    checkOutput("rstmid.restart.do", 32'(do_o), 32'h020100);
    checkOutput("rstmid.restart.vs", 32'(vs_o), 32'h1);

    // Zero width holds IDLE until a legal width appears
    doReset();
    setConfig(0, 2, 3, 5, 1, 0, 0);
    en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycles(1);
      checkOutput($sformatf("zero.c%0d.busy", i), 32'(busy_o), 32'h0);
      checkOutput($sformatf("zero.c%0d.de", i),   32'(de_o),   32'h0);
    end
    reg_width = CW'(4);
    stepCycles(1);
    checkOutput("zero.start.busy", 32'(busy_o), 32'h1);
    checkOutput("zero.start.de",   32'(de_o),   32'h1);
    checkOutput("zero.start.hs",   32'(hs_o),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
